mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit in the MEM stage of the RISC-V pipeline. It takes the control decoder's `mem_write`, `mem_width` and `mem_sign_extend` fields together with the ALU address and store data. It drives a 32-bit word-organised memory port through a req/ack handshake, with byte-lane alignment, splitting of word-crossing accesses, and load-data extension. It stalls the pipeline until the access completes.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 = accesses that cross a word boundary are split into two beats; 0 = they raise `err_o` and perform no access.
- `clk_i`  input  1  clock; all state changes on the rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `req_i`  input  1  the MEM-stage instruction is a load or store.
- `mem_write_i`  input  1  1 = store, 0 = load.
- `mem_width_i`  input  2  00 byte, 01 half, 10 word, 11 reserved.
- `mem_sign_extend_i`  input  1  1 = sign-extend load data, 0 = zero-extend.
- `addr_i`  input  32  byte address.
- `wdata_i`  input  32  store data, right-justified.
- `stall_o`  output  1  hold the pipeline.
- `done_o`  output  1  one-cycle pulse: the access completed.
- `err_o`  output  1  one-cycle pulse: reserved width, or misaligned access with `SPLIT_MISALIGNED`=0.
- `rdata_o`  output  32  extended load result; valid while `done_o` is high and held until the next `done_o`.
- `mem_req_o`  output  1  memory request.
- `mem_we_o`  output  1  write enable.
- `mem_addr_o`  output  32  word address; bits [1:0] are always 00.
- `mem_be_o`  output  4  byte-lane enables; bit n covers bits [8n+7:8n].
- `mem_wdata_o`  output  32  write data, lane-aligned.
- `mem_ack_i`  input  1  beat accepted / read data valid.
- `mem_rdata_i`  input  32  read word.

## Operation
- Access parameters:
  - bytes N = 1/2/4 for width 00/01/10.
  - offset = `addr_i[1:0]`.
  - Lane data: `wdata_i` rotated left by 8×offset; the same rotated word is presented on both beats.
- States: IDLE, BEAT1, BEAT2, DONE.
- IDLE, with `req_i`=1, all inputs are sampled and registered:
  - Width 11: go to DONE with `err_o` and no memory request.
  - offset+N>4 and `SPLIT_MISALIGNED`=0: same as width 11.
  - Otherwise: go to BEAT1.
- BEAT1:
  - `mem_addr_o` = {addr[31:2],00}.
  - `mem_be_o` = lanes offset..min(offset+N-1,3).
  - On ack: if offset+N>4, go to BEAT2; otherwise go to DONE.
- BEAT2:
  - `mem_addr_o` = {addr[31:2],00}+4, wrapping 0xFFFFFFFC→0x00000000.
  - `mem_be_o` = lanes 0..offset+N-5.
  - On ack: go to DONE.
- Load assembly:
  - On each acked beat, the enabled lanes of `mem_rdata_i` are latched into a 32-bit buffer; other lanes are left untouched.
  - In DONE the buffer is rotated right by 8×offset.
  - The result is masked to N bytes and extended per `mem_sign_extend_i`; a word load ignores the extension flag.
  - On a load, `rdata_o` is updated in DONE.
- Stores leave `rdata_o` unchanged. `mem_we_o` = `mem_write_i` for every beat.
- DONE: `done_o` or `err_o` pulses, `stall_o`=0, and the state returns to IDLE. `req_i` in the DONE cycle belongs to the retiring instruction and is ignored.

## Timing
- Reset (`rst_i`=0, asynchronous): state is IDLE and every output is 0, including `stall_o` (forced low during reset) and `rdata_o`. A reset mid-access drops `mem_req_o` immediately; the pending beat is abandoned with no done/err pulse.
- `stall_o`: combinational. It is 1 when (IDLE and `req_i`), or in BEAT1 or BEAT2. It is 0 in DONE and while in reset.
- Handshake:
  - `mem_req_o`=1 throughout BEAT1/BEAT2.
  - Address, be, we and wdata are registered and stable until ack.
  - Ack is sampled on the rising edge while `mem_req_o`=1; ack in the same cycle as the request's first cycle is legal.
  - `mem_ack_i` outside BEAT1/BEAT2 is ignored.
  - Between beats, `mem_req_o` stays high; the address and be change on the edge that samples the first ack.
- Latency with zero-wait memory (ack=1 always), counted from the IDLE request cycle:
  - Aligned access: BEAT1 in cycle 1, DONE in cycle 2, so `stall_o` is high for 2 cycles.
  - Split access: DONE in cycle 3.
  - Error: DONE in cycle 1.
- Each wait cycle (ack=0) adds one cycle.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE.

## Test plan
- Aligned word load: addr 0x100, memory returns 0x8899AABB with ack on the first beat → single beat with be=1111, `done_o` in cycle 2, `rdata_o`=0x8899AABB.
- Signed byte load: addr 0x103, mem 0x80112233 → be=1000, `rdata_o`=0xFFFFFF80. Repeat with `mem_sign_extend_i`=0 → `rdata_o`=0x00000080.
- Split half store: addr 0x203, wdata 0x0000BEEF → beat1 at 0x200 with be=1000, wdata 0xEF0000BE; beat2 at 0x204 with be=0001, same wdata; `done_o` in cycle 3.
- Split word load across the top address: addr 0xFFFFFFFE, beat1 rdata 0xDDCC0000, beat2 rdata 0x0000FFEE → beat2 address 0x00000000, `rdata_o`=0xFFEEDDCC.
- Wait states and reset: ack held low for 3 cycles → `mem_req_o` and `mem_addr_o` stable, `stall_o`=1 throughout. Assert `rst_i`=0 mid-wait → all outputs 0 asynchronously; after release, the unit is IDLE and accepts a new request.
- Errors: width 11, then a misaligned word at 0x1 with `SPLIT_MISALIGNED`=0 → `err_o` pulse in cycle 1 for each, `mem_req_o` never asserted, `rdata_o` unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: byte-lane alignment, word-crossing split,
// req/ack handshake to a word-organised memory port and load-data extension.
module mem_access_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_width_i,
    input  logic        mem_sign_extend_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_DONE} state_t;

    function automatic logic [3:0] width_mask(input logic [1:0] width);
        case (width)
            2'b00:   width_mask = 4'b0001;
            2'b01:   width_mask = 4'b0011;
            default: width_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
        case (off)
            2'd0:    rotl_bytes = w;
            2'd1:    rotl_bytes = {w[23:0], w[31:24]};
            2'd2:    rotl_bytes = {w[15:0], w[31:16]};
            default: rotl_bytes = {w[7:0], w[31:8]};
        endcase
    endfunction

    function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] off);
        case (off)
            2'd0:    rotr_bytes = w;
            2'd1:    rotr_bytes = {w[7:0], w[31:8]};
            2'd2:    rotr_bytes = {w[15:0], w[31:16]};
            default: rotr_bytes = {w[23:0], w[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] width,
                                           input logic sext);
        case (width)
            2'b00:   extend = {{24{sext & w[7]}}, w[7:0]};
            2'b01:   extend = {{16{sext & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  width_q, width_d;
    logic        sext_q, sext_d;
    logic        split_q, split_d;
    logic [3:0]  be2_q, be2_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [7:0]  lanes8;
    logic        crosses;
    logic [31:0] merged;
    logic        last_ack;

    // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next word.
    assign lanes8  = {4'b0000, width_mask(mem_width_i)} << addr_i[1:0];
    assign crosses = |lanes8[7:4];

    always_comb begin
        merged = buf_q;
        for (int i = 0; i < 4; i++) begin
            if (mem_be_q[i]) merged[8*i +: 8] = mem_rdata_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        width_d     = width_q;
        sext_d      = sext_q;
        split_d     = split_q;
        be2_d       = be2_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        last_ack    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    off_d   = addr_i[1:0];
                    width_d = mem_width_i;
                    sext_d  = mem_sign_extend_i;
                    if (mem_width_i == 2'b11 || (crosses && !SPLIT_MISALIGNED)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        split_d     = crosses;
                        be2_d       = lanes8[7:4];
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write_i;
                        mem_addr_d  = {addr_i[31:2], 2'b00};
                        mem_be_d    = lanes8[3:0];
                        mem_wdata_d = rotl_bytes(wdata_i, addr_i[1:0]);
                        state_d     = S_BEAT1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ack_i) begin
                    buf_d = merged;
                    if (split_q) begin
                        mem_addr_d = mem_addr_q + 32'd4;
                        mem_be_d   = be2_q;
                        state_d    = S_BEAT2;
                    end else begin
                        last_ack = 1'b1;
                    end
                end
            end
            S_BEAT2: begin
                if (mem_ack_i) begin
                    buf_d    = merged;
                    last_ack = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result is registered on the final ack so it is valid during the DONE cycle.
        if (last_ack) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            mem_be_d  = 4'b0000;
            if (!mem_we_q) rdata_d = extend(rotr_bytes(merged, off_q), width_q, sext_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            off_q       <= 2'b00;
            width_q     <= 2'b00;
            sext_q      <= 1'b0;
            split_q     <= 1'b0;
            be2_q       <= 4'b0000;
            buf_q       <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            width_q     <= width_d;
            sext_q      <= sext_d;
            split_q     <= split_d;
            be2_q       <= be2_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign stall_o     = rst_i & ((state_q == S_IDLE && req_i) ||
                                  state_q == S_BEAT1 || state_q == S_BEAT2);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned, split, wait-state, reset and error accesses.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req2, we, sext, ack;
    logic [1:0]  width;
    logic [31:0] addr, wdata, mrdata;

    logic        stall, done, err, mreq, mwe;
    logic [31:0] rdata, maddr, mwdata;
    logic [3:0]  mbe;
    logic        stall2, done2, err2, mreq2, mwe2;
    logic [31:0] rdata2, maddr2, mwdata2;
    logic [3:0]  mbe2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .mem_write_i(we), .mem_width_i(width),
        .mem_sign_extend_i(sext), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall), .done_o(done), .err_o(err), .rdata_o(rdata),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_be_o(mbe),
        .mem_wdata_o(mwdata), .mem_ack_i(ack), .mem_rdata_i(mrdata)
    );

    mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk_i(clk), .rst_i(rst_n), .req_i(req2), .mem_write_i(we), .mem_width_i(width),
        .mem_sign_extend_i(sext), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall2), .done_o(done2), .err_o(err2), .rdata_o(rdata2),
        .mem_req_o(mreq2), .mem_we_o(mwe2), .mem_addr_o(maddr2), .mem_be_o(mbe2),
        .mem_wdata_o(mwdata2), .mem_ack_i(ack), .mem_rdata_i(mrdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] wd, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; width = wd; sext = s; addr = a; wdata = d;
        #0;
    endtask

    task automatic test_reset();
        req = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if ({done, err, mreq, mwe, mbe} !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl: got %h want 00", {done, err, mreq, mwe, mbe}); end
        n_cmp++; if (rdata !== 32'h0 || maddr !== 32'h0 || mwdata !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0", rdata, maddr, mwdata); end
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL wl_stall_c0: got %b want 1", stall); end
        tick(); req = 1'b0;
        n_cmp++; if (mreq !== 1'b1 || maddr !== 32'h100 || mbe !== 4'b1111 || mwe !== 1'b0) begin n_bad++; $display("FAIL wl_beat1: got req=%b addr=%h be=%b we=%b want 1/100/1111/0", mreq, maddr, mbe, mwe); end
        n_cmp++; if (stall !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL wl_c1: got stall=%b done=%b want 1/0", stall, done); end
        ack = 1'b1; mrdata = 32'h8899_AABB;
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || stall !== 1'b0 || mreq !== 1'b0) begin n_bad++; $display("FAIL wl_done: got done=%b stall=%b req=%b want 1/0/0", done, stall, mreq); end
        n_cmp++; if (rdata !== 32'h8899_AABB) begin n_bad++; $display("FAIL wl_rdata: got %h want 8899aabb", rdata); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wl_pulse: got %b want 0", done); end
    endtask

    task automatic test_byte_load(input logic s, input logic [31:0] exp);
        issue(1'b0, 2'b00, s, 32'h0000_0103, 32'h0);
        tick(); req = 1'b0;
        n_cmp++; if (maddr !== 32'h100 || mbe !== 4'b1000) begin n_bad++; $display("FAIL bl_beat1: got addr=%h be=%b want 100/1000", maddr, mbe); end
        ack = 1'b1; mrdata = 32'h8011_2233;
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== exp) begin n_bad++; $display("FAIL bl_rdata_s%0d: got done=%b rdata=%h want 1/%h", s, done, rdata, exp); end
        tick();
    endtask

    task automatic test_split_store();
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_BEEF);
        tick(); req = 1'b0;
        n_cmp++; if (maddr !== 32'h200 || mbe !== 4'b1000 || mwdata !== 32'hEF00_00BE || mwe !== 1'b1) begin n_bad++; $display("FAIL ss_beat1: got addr=%h be=%b wd=%h we=%b want 200/1000/ef0000be/1", maddr, mbe, mwdata, mwe); end
        ack = 1'b1;
        tick();
        n_cmp++; if (mreq !== 1'b1 || maddr !== 32'h204 || mbe !== 4'b0001 || mwdata !== 32'hEF00_00BE || mwe !== 1'b1) begin n_bad++; $display("FAIL ss_beat2: got req=%b addr=%h be=%b wd=%h we=%b want 1/204/0001/ef0000be/1", mreq, maddr, mbe, mwdata, mwe); end
        n_cmp++; if (stall !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ss_c2: got stall=%b done=%b want 1/0", stall, done); end
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL ss_done: got done=%b rdata=%h want 1/00000080", done, rdata); end
        tick();
    endtask

    task automatic test_split_top();
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
        tick(); req = 1'b0;
        n_cmp++; if (maddr !== 32'hFFFF_FFFC || mbe !== 4'b1100) begin n_bad++; $display("FAIL st_beat1: got addr=%h be=%b want fffffffc/1100", maddr, mbe); end
        ack = 1'b1; mrdata = 32'hDDCC_0000;
        tick();
        n_cmp++; if (maddr !== 32'h0000_0000 || mbe !== 4'b0011 || mreq !== 1'b1) begin n_bad++; $display("FAIL st_beat2: got addr=%h be=%b req=%b want 00000000/0011/1", maddr, mbe, mreq); end
        mrdata = 32'h0000_FFEE;
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== 32'hFFEE_DDCC) begin n_bad++; $display("FAIL st_rdata: got done=%b rdata=%h want 1/ffeeddcc", done, rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
        tick(); req = 1'b0;
        n_cmp++; if (mbe !== 4'b0010) begin n_bad++; $display("FAIL bb_be1: got %b want 0010", mbe); end
        ack = 1'b1; mrdata = 32'h0000_AB00;
        tick(); ack = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_005A);
        n_cmp++; if (done !== 1'b1 || rdata !== 32'h0000_00AB || stall !== 1'b0) begin n_bad++; $display("FAIL bb_done1: got done=%b rdata=%h stall=%b want 1/000000ab/0", done, rdata, stall); end
        tick();
        n_cmp++; if (stall !== 1'b1 || mreq !== 1'b0) begin n_bad++; $display("FAIL bb_idle: got stall=%b req=%b want 1/0", stall, mreq); end
        tick(); req = 1'b0;
        n_cmp++; if (mreq !== 1'b1 || mbe !== 4'b0100 || mwdata !== 32'h005A_0000 || mwe !== 1'b1) begin n_bad++; $display("FAIL bb_beat2: got req=%b be=%b wd=%h we=%b want 1/0100/005a0000/1", mreq, mbe, mwdata, mwe); end
        ack = 1'b1;
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== 32'h0000_00AB) begin n_bad++; $display("FAIL bb_store: got done=%b rdata=%h want 1/000000ab", done, rdata); end
        tick();
    endtask

    task automatic test_wait_reset();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        ack = 1'b0;
        tick(); req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (mreq !== 1'b1 || maddr !== 32'h300 || stall !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL wt_hold%0d: got req=%b addr=%h stall=%b done=%b want 1/300/1/0", c, mreq, maddr, stall, done); end
            if (c < 2) tick();
        end
        #2 rst_n = 1'b0; req = 1'b1;
        #1;
        n_cmp++; if (mreq !== 1'b0 || maddr !== 32'h0 || mbe !== 4'b0 || stall !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wt_rst: got req=%b addr=%h be=%b stall=%b done=%b err=%b want all 0", mreq, maddr, mbe, stall, done, err); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL wt_rst_rdata: got %h want 0", rdata); end
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0302, 32'h0);
        n_cmp++; if (stall !== 1'b1 || mreq !== 1'b0) begin n_bad++; $display("FAIL wt_idle: got stall=%b req=%b want 1/0", stall, mreq); end
        tick(); req = 1'b0;
        n_cmp++; if (mreq !== 1'b1 || maddr !== 32'h300 || mbe !== 4'b1100) begin n_bad++; $display("FAIL wt_new: got req=%b addr=%h be=%b want 1/300/1100", mreq, maddr, mbe); end
        ack = 1'b1; mrdata = 32'h8001_1234;
        tick(); ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL wt_rdata: got done=%b rdata=%h want 1/ffff8001", done, rdata); end
        tick();
    endtask

    task automatic test_errors();
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        ack = 1'b1;
        n_cmp++; if (stall !== 1'b1 || mreq !== 1'b0) begin n_bad++; $display("FAIL er_w_c0: got stall=%b req=%b want 1/0", stall, mreq); end
        tick(); req = 1'b0;
        n_cmp++; if (err !== 1'b1 || done !== 1'b0 || mreq !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL er_width: got err=%b done=%b req=%b stall=%b want 1/0/0/0", err, done, mreq, stall); end
        n_cmp++; if (rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL er_w_rdata: got %h want ffff8001", rdata); end
        tick();
        n_cmp++; if (err !== 1'b0 || mreq !== 1'b0) begin n_bad++; $display("FAIL er_w_after: got err=%b req=%b want 0/0", err, mreq); end
        req2 = 1'b1; we = 1'b0; width = 2'b10; sext = 1'b0; addr = 32'h0000_0001;
        #0;
        n_cmp++; if (stall2 !== 1'b1 || mreq2 !== 1'b0) begin n_bad++; $display("FAIL er_m_c0: got stall=%b req=%b want 1/0", stall2, mreq2); end
        tick(); req2 = 1'b0;
        n_cmp++; if (err2 !== 1'b1 || done2 !== 1'b0 || mreq2 !== 1'b0 || rdata2 !== 32'h0) begin n_bad++; $display("FAIL er_misal: got err=%b done=%b req=%b rdata=%h want 1/0/0/0", err2, done2, mreq2, rdata2); end
        tick();
        n_cmp++; if (err2 !== 1'b0 || mreq2 !== 1'b0) begin n_bad++; $display("FAIL er_m_after: got err=%b req=%b want 0/0", err2, mreq2); end
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; width = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0; ack = 1'b0; mrdata = 32'h0;
        tick();
        test_reset();
        test_word_load();
        test_byte_load(1'b1, 32'hFFFF_FF80);
        test_byte_load(1'b0, 32'h0000_0080);
        test_split_store();
        test_split_top();
        test_back_to_back();
        test_wait_reset();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
